// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction-fetch stage of the uP16 five-stage pipeline, directly upstream of
// ID. It owns the PC, issues in-order requests to a variable-latency
// instruction memory, and buffers returned instructions in a small prefetch
// FIFO. It drives the IF/ID pipeline register (inst, PCplus1, inst_valid).
// A taken branch reported by ID redirects fetch and squashes wrong-path work.
//
// Handshakes:
//   imem request : a request is accepted on a rising edge where
//                  imem_req & imem_ready. imem_req never depends on imem_ready.
//   imem response: imem_valid marks one in-order response per cycle. No
//                  back-pressure is applied, because the credit rule
//                  (pending + buffered <= FQ_DEPTH) always leaves room.
//   IF/ID        : stall_i freezes the IF/ID register and the FIFO read side.
//                  Fetch continues while credit remains.
//
// Ports:
//   Clk         in   clock, all state changes on posedge
//   Rst_n       in   synchronous reset, active-low
//   stall_i     in   ID hold request
//   sel_PC      in   branch taken (from ID)
//   alt_PC      in   branch target (from ID)
//   imem_addr   out  fetch address (= PC)
//   imem_req    out  fetch request
//   imem_ready  in   memory can accept a request this cycle
//   imem_rdata  in   returned instruction
//   imem_valid  in   one in-order response this cycle
//   inst        out  IF/ID instruction
//   PCplus1     out  IF/ID address of inst + 1
//   inst_valid  out  IF/ID holds a real (non-bubble) instruction
// -----------------------------------------------------------------------------
module if_fetch_unit #(
   parameter int               ISIZE    = 18,
   parameter int               DSIZE    = 16,
   parameter int               FQ_DEPTH = 4,
   parameter logic [DSIZE-1:0] RESET_PC = '0,
   parameter logic [ISIZE-1:0] NOP_INST = '0
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             stall_i,
   input  logic             sel_PC,
   input  logic [DSIZE-1:0] alt_PC,
   output logic [DSIZE-1:0] imem_addr,
   output logic             imem_req,
   input  logic             imem_ready,
   input  logic [ISIZE-1:0] imem_rdata,
   input  logic             imem_valid,
   output logic [ISIZE-1:0] inst,
   output logic [DSIZE-1:0] PCplus1,
   output logic             inst_valid
);

   // Pointer width for the FIFO and tag queue, and counter width able to
   // hold the value FQ_DEPTH itself.
   localparam int              PW      = $clog2(FQ_DEPTH);
   localparam int              CW      = PW + 1;
   localparam logic [CW-1:0]   DEPTH_C = CW'(FQ_DEPTH);
   localparam logic [CW-1:0]   ONE_C   = CW'(1);
   localparam logic [PW-1:0]   PTR_ONE = PW'(1);
   localparam logic [DSIZE-1:0] ADDR_ONE = DSIZE'(1);

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   logic [DSIZE-1:0] r_pc;

   // Prefetch FIFO of {instruction, address+1}
   logic [ISIZE-1:0] r_fq_inst [FQ_DEPTH];
   logic [DSIZE-1:0] r_fq_pcp1 [FQ_DEPTH];
   logic [PW-1:0]    r_fq_wr;
   logic [PW-1:0]    r_fq_rd;
   logic [CW-1:0]    r_cnt;

   // Responses still owed by the memory, and how many of them are wrong-path
   logic [CW-1:0]    r_pend;
   logic [CW-1:0]    r_disc;

   // Addresses of outstanding requests, in issue order
   logic [DSIZE-1:0] r_tag [FQ_DEPTH];
   logic [PW-1:0]    r_tag_wr;
   logic [PW-1:0]    r_tag_rd;

   // IF/ID pipeline register
   logic [ISIZE-1:0] r_inst;
   logic [DSIZE-1:0] r_pcp1;
   logic             r_inst_valid;

   // ---------------------------------------------------------------------------
   // Combinational control
   // ---------------------------------------------------------------------------
   logic             w_redir;
   logic [CW:0]      w_inflight;
   logic             w_credit_ok;
   logic             w_req;
   logic             w_accept;
   logic             w_resp;
   logic             w_drop;
   logic             w_push;
   logic             w_pop;
   logic [DSIZE-1:0] w_resp_pcp1;
   logic [CW-1:0]    w_pend_nxt;
   logic [CW-1:0]    w_disc_nxt;
   logic [CW-1:0]    w_cnt_nxt;

   // A branch sitting in ID under stall only takes effect once the stall
   // releases, so the redirect is qualified by ~stall_i.
   assign w_redir = sel_PC & r_inst_valid & ~stall_i;

   // Credit counts every response still owed (including ones that will be
   // discarded) plus every buffered instruction, using registered values only.
   assign w_inflight  = {1'b0, r_pend} + {1'b0, r_cnt};
   assign w_credit_ok = (w_inflight < {1'b0, DEPTH_C});

   // No request in a redirect cycle: the PC is about to be replaced.
   assign w_req    = Rst_n & ~w_redir & w_credit_ok;
   assign w_accept = w_req & imem_ready;

   // A response with nothing outstanding is a protocol error and is ignored.
   assign w_resp = imem_valid & (r_pend != '0);

   // Wrong-path responses are those already counted in r_disc, or any response
   // landing in the very cycle the redirect is taken.
   assign w_drop = w_resp & ((r_disc != '0) | w_redir);
   assign w_push = w_resp & ~w_drop;
   assign w_pop  = ~stall_i & ~w_redir & (r_cnt != '0);

   // Address+1 of the response, wrapping naturally at 2^DSIZE
   assign w_resp_pcp1 = r_tag[r_tag_rd] + ADDR_ONE;

   always_comb begin
      w_pend_nxt = r_pend;
      if (w_accept && !w_resp) begin
         w_pend_nxt = r_pend + ONE_C;
      end else if (!w_accept && w_resp) begin
         w_pend_nxt = r_pend - ONE_C;
      end
   end

   // On redirect every response still owed after this cycle is wrong-path.
   always_comb begin
      w_disc_nxt = r_disc;
      if (w_redir) begin
         w_disc_nxt = w_pend_nxt;
      end else if (w_resp && (r_disc != '0)) begin
         w_disc_nxt = r_disc - ONE_C;
      end
   end

   always_comb begin
      w_cnt_nxt = r_cnt;
      if (w_redir) begin
         w_cnt_nxt = '0;
      end else if (w_push && !w_pop) begin
         w_cnt_nxt = r_cnt + ONE_C;
      end else if (w_pop && !w_push) begin
         w_cnt_nxt = r_cnt - ONE_C;
      end
   end

   // ---------------------------------------------------------------------------
   // PC
   // ---------------------------------------------------------------------------
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         r_pc <= RESET_PC;
      end else if (w_redir) begin
         r_pc <= alt_PC;
      end else if (w_accept) begin
         r_pc <= r_pc + ADDR_ONE;
      end
   end

   // ---------------------------------------------------------------------------
   // Pending / discard counters
   // ---------------------------------------------------------------------------
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         r_pend <= '0;
         r_disc <= '0;
      end else begin
         r_pend <= w_pend_nxt;
         r_disc <= w_disc_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // Tag queue: one entry per outstanding request, popped on every response
   // (kept or dropped) so it stays aligned with the memory's in-order replies.
   // ---------------------------------------------------------------------------
   always_ff @(posedge Clk) begin
      if (w_accept) begin
         r_tag[r_tag_wr] <= r_pc;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         r_tag_wr <= '0;
         r_tag_rd <= '0;
      end else begin
         if (w_accept) begin
            r_tag_wr <= r_tag_wr + PTR_ONE;
         end
         if (w_resp) begin
            r_tag_rd <= r_tag_rd + PTR_ONE;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Prefetch FIFO
   // ---------------------------------------------------------------------------
   always_ff @(posedge Clk) begin
      if (w_push) begin
         r_fq_inst[r_fq_wr] <= imem_rdata;
         r_fq_pcp1[r_fq_wr] <= w_resp_pcp1;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         r_fq_wr <= '0;
         r_fq_rd <= '0;
         r_cnt   <= '0;
      end else if (w_redir) begin
         r_fq_wr <= '0;
         r_fq_rd <= '0;
         r_cnt   <= '0;
      end else begin
         if (w_push) begin
            r_fq_wr <= r_fq_wr + PTR_ONE;
         end
         if (w_pop) begin
            r_fq_rd <= r_fq_rd + PTR_ONE;
         end
         r_cnt <= w_cnt_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // IF/ID register. PCplus1 is left alone on bubbles; only inst_valid
   // tells ID whether the contents are meaningful.
   // ---------------------------------------------------------------------------
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         r_inst       <= NOP_INST;
         r_pcp1       <= '0;
         r_inst_valid <= 1'b0;
      end else if (!stall_i) begin
         if (w_redir) begin
            r_inst       <= NOP_INST;
            r_inst_valid <= 1'b0;
         end else if (r_cnt != '0) begin
            r_inst       <= r_fq_inst[r_fq_rd];
            r_pcp1       <= r_fq_pcp1[r_fq_rd];
            r_inst_valid <= 1'b1;
         end else begin
            r_inst       <= NOP_INST;
            r_inst_valid <= 1'b0;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign imem_req   = w_req;
   assign imem_addr  = r_pc;
   assign inst       = r_inst;
   assign PCplus1    = r_pcp1;
   assign inst_valid = r_inst_valid;

   // The credit rule keeps pending + buffered <= FQ_DEPTH, so a push can never
   // land on a full FIFO, and discards are always a subset of pending.
   a_no_push_full: assert property (@(posedge Clk) disable iff (!Rst_n)
      !(w_push && (r_cnt == DEPTH_C)));
   a_disc_le_pend: assert property (@(posedge Clk) disable iff (!Rst_n)
      (r_disc <= r_pend));

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

   localparam int          ISIZE    = 18;
   localparam int          DSIZE    = 16;
   localparam int          FQ_DEPTH = 4;
   localparam logic [15:0] RESET_PC = 16'hFFFE;
   localparam logic [17:0] NOP_INST = 18'h0;

   logic        Clk = 1'b0;
   logic        Rst_n;
   logic        stall_i;
   logic        sel_PC;
   logic [15:0] alt_PC;
   logic [15:0] imem_addr;
   logic        imem_req;
   logic        imem_ready;
   logic [17:0] imem_rdata;
   logic        imem_valid;
   logic [17:0] inst;
   logic [15:0] PCplus1;
   logic        inst_valid;

   // ------------------------------------------------------------------ clock
   always #5 Clk = ~Clk;

   if_fetch_unit #(
      .ISIZE(ISIZE), .DSIZE(DSIZE), .FQ_DEPTH(FQ_DEPTH),
      .RESET_PC(RESET_PC), .NOP_INST(NOP_INST)
   ) dut (
      .Clk(Clk), .Rst_n(Rst_n), .stall_i(stall_i), .sel_PC(sel_PC),
      .alt_PC(alt_PC), .imem_addr(imem_addr), .imem_req(imem_req),
      .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .imem_valid(imem_valid), .inst(inst), .PCplus1(PCplus1),
      .inst_valid(inst_valid)
   );

   // ------------------------------------------------------------ bookkeeping
   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp,
                  $time);
      end
   endtask

   // Program image: distinct, never equal to the NOP encoding.
   function automatic logic [17:0] rom(input logic [15:0] a);
      rom = {a[1:0] ^ 2'b10, a ^ 16'h5A3C};
   endfunction

   // -------------------------------------------------------------- reference
   // ID must see the program-order stream starting at RESET_PC, continuing
   // from alt_PC after every taken branch. Each entry is {inst, addr+1}.
   logic [33:0] exp_q[$];
   logic [15:0] exp_next;

   task automatic top_up();
      while (exp_q.size() < 8) begin
         exp_q.push_back({rom(exp_next), exp_next + 16'd1});
         exp_next = exp_next + 16'd1;
      end
   endtask

   task automatic restart_stream(input logic [15:0] a);
      exp_q.delete();
      exp_next = a;
      top_up();
   endtask

   // ----------------------------------------------------------- memory model
   typedef struct {
      logic [15:0] addr;
      int          due;
   } mreq_t;

   mreq_t mem_q[$];
   mreq_t mq_dummy;
   int    cyc         = 0;
   int    mem_lat     = 1;
   bit    rdy_rand    = 1'b0;
   bit    spurious_en = 1'b0;
   bit    drove_real  = 1'b0;

   initial begin : memory
      logic        acc;
      logic [15:0] acc_addr;
      logic        rst_s;
      imem_ready = 1'b1;
      imem_valid = 1'b0;
      imem_rdata = '0;
      forever begin
         @(negedge Clk);
         acc      = imem_req & imem_ready;
         acc_addr = imem_addr;
         rst_s    = Rst_n;
         @(posedge Clk);
         #1;
         cyc++;
         if (!rst_s) begin
            mem_q.delete();
         end else begin
            if (drove_real) mq_dummy = mem_q.pop_front();
            if (acc) mem_q.push_back('{acc_addr, cyc + mem_lat - 1});
            chk("outstanding_le_depth", 64'(mem_q.size() <= FQ_DEPTH), 64'd1);
         end
         drove_real = 1'b0;
         imem_valid = 1'b0;
         imem_rdata = 18'($urandom);
         if (rst_s && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_valid = 1'b1;
            imem_rdata = rom(mem_q[0].addr);
            drove_real = 1'b1;
         end else if (spurious_en && rst_s && mem_q.size() == 0 &&
                      $urandom_range(0, 9) == 0) begin
            imem_valid = 1'b1;   // response with nothing outstanding
         end
         imem_ready = rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
   end

   // ---------------------------------------------------------------- monitor
   int          n_loaded = 0;
   logic        last_stall = 1'b0;
   logic        last_rst   = 1'b0;
   logic        held_valid = 1'b0;
   logic [17:0] held_inst;
   logic [15:0] held_pcp1;

   initial begin : monitor
      logic [33:0] e;
      forever begin
         @(negedge Clk);
         if (!last_rst) begin
            chk("reset_valid", 64'(inst_valid), 64'd0);
            chk("reset_inst", 64'(inst), 64'(NOP_INST));
            held_valid = 1'b0;
         end else if (!last_stall) begin
            if (inst_valid) begin
               if (exp_q.size() == 0) begin
                  chk("exp_q_nonempty", 64'd0, 64'd1);
               end else begin
                  e = exp_q.pop_front();
                  chk("stream_inst", 64'(inst), 64'(e[33:16]));
                  chk("stream_pcplus1", 64'(PCplus1), 64'(e[15:0]));
                  held_inst = e[33:16];
                  held_pcp1 = e[15:0];
               end
               held_valid = 1'b1;
               n_loaded++;
            end else begin
               chk("bubble_nop", 64'(inst), 64'(NOP_INST));
               held_valid = 1'b0;
            end
         end else begin
            chk("hold_valid", 64'(inst_valid), 64'(held_valid));
            chk("hold_inst", 64'(inst), held_valid ? 64'(held_inst) : 64'(NOP_INST));
            if (held_valid) chk("hold_pcplus1", 64'(PCplus1), 64'(held_pcp1));
         end
         last_stall = stall_i;
         last_rst   = Rst_n;
      end
   end

   // ----------------------------------------------------------------- driver
   logic        pend_redir = 1'b0;
   logic [15:0] pend_alt   = '0;

   task automatic tick();
      @(posedge Clk);
      #1;
      if (pend_redir) begin
         restart_stream(pend_alt);
         pend_redir = 1'b0;
      end
      top_up();
   endtask

   task automatic drive(input logic s, input logic b, input logic [15:0] alt);
      stall_i = s;
      sel_PC  = b;
      alt_PC  = alt;
      if (b && inst_valid && !s && Rst_n) begin
         pend_redir = 1'b1;
         pend_alt   = alt;
      end
   endtask

   task automatic do_reset(input int n);
      pend_redir = 1'b0;
      Rst_n = 1'b0;
      drive(1'b0, 1'b0, 16'h0);
      repeat (n) begin
         tick();
         chk("rst_inst_valid", 64'(inst_valid), 64'd0);
         chk("rst_inst", 64'(inst), 64'(NOP_INST));
         chk("rst_pcplus1", 64'(PCplus1), 64'd0);
         chk("rst_imem_req", 64'(imem_req), 64'd0);
         chk("rst_imem_addr", 64'(imem_addr), 64'(RESET_PC));
      end
      Rst_n = 1'b1;
      restart_stream(RESET_PC);
   endtask

   // First instruction valid after the third edge, then one per cycle.
   task automatic freerun_check(input int n, input bit wrap_chk);
      for (int k = 1; k <= n; k++) begin
         tick();
         drive(1'b0, 1'b0, 16'h0);
         chk("freerun_valid", 64'(inst_valid), 64'(k >= 3));
         if (wrap_chk && k == 3) chk("wrap_pcp1_a", 64'(PCplus1), 64'h0FFFF);
         if (wrap_chk && k == 4) chk("wrap_pcp1_b", 64'(PCplus1), 64'h00000);
         if (wrap_chk && k == 5) chk("wrap_pcp1_c", 64'(PCplus1), 64'h00001);
      end
   endtask

   task automatic wait_for(input logic [15:0] pcp1, input int budget);
      int n;
      n = 0;
      while (!(inst_valid && PCplus1 == pcp1) && n < budget) begin
         tick();
         drive(1'b0, 1'b0, 16'h0);
         n++;
      end
      chk("wait_target", 64'(inst_valid && PCplus1 == pcp1), 64'd1);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin : main
      int base;
      Rst_n   = 1'b0;
      stall_i = 1'b0;
      sel_PC  = 1'b0;
      alt_PC  = '0;
      restart_stream(RESET_PC);

      // Reset, then free-run through the 0xFFFF -> 0x0000 wrap
      do_reset(3);
      freerun_check(10, 1'b1);

      // Stall for 3 cycles while inst is address 12
      wait_for(16'd13, 40);
      for (int s = 0; s < 3; s++) begin
         drive(1'b1, 1'b0, 16'h0);
         #1;
         chk("stall_req", 64'(imem_req), 64'(s < 2));
         tick();
         chk("stall_inst", 64'(inst), 64'(rom(16'd12)));
      end
      drive(1'b0, 1'b0, 16'h0);
      #1;
      chk("release_req_full", 64'(imem_req), 64'd0);
      for (int k = 0; k < 6; k++) begin
         tick();
         drive(1'b0, 1'b0, 16'h0);
         chk("release_no_gap", 64'(inst_valid), 64'd1);
      end

      // Taken branch at address 20 to 0x40
      wait_for(16'd21, 20);
      drive(1'b0, 1'b1, 16'h0040);
      tick();
      drive(1'b0, 1'b0, 16'h0);
      chk("br_bubble_valid", 64'(inst_valid), 64'd0);
      chk("br_bubble_inst", 64'(inst), 64'(NOP_INST));
      tick();
      chk("br_wait1", 64'(inst_valid), 64'd0);
      tick();
      chk("br_wait2", 64'(inst_valid), 64'd0);
      tick();
      chk("br_target_valid", 64'(inst_valid), 64'd1);
      chk("br_target_pcp1", 64'(PCplus1), 64'h41);
      chk("br_target_inst", 64'(inst), 64'(rom(16'h0040)));

      // Variable latency, toggling ready, random stalls/branches, stray valids
      mem_lat     = 3;
      rdy_rand    = 1'b1;
      spurious_en = 1'b1;
      base        = n_loaded;
      for (int k = 0; k < 400; k++) begin
         tick();
         drive($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
               16'($urandom));
      end
      chk("random_progress", 64'((n_loaded - base) > 40), 64'd1);

      // Reset in the middle of a stalled, busy run
      rdy_rand    = 1'b0;
      spurious_en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         drive(1'b1, 1'b0, 16'h0);
      end
      do_reset(1);
      mem_lat = 1;
      freerun_check(12, 1'b1);

      // Drain
      for (int k = 0; k < 5; k++) begin
         tick();
         drive(1'b0, 1'b0, 16'h0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
